// File: rtl/simon_round_core.sv
// simon_round_core: iterative Simon 128/256 round datapath.
// One round per clock, 72 rounds. Encrypts (ctrl=0) or decrypts (ctrl=1) one
// 128-bit block using round keys read from the key-schedule memory via key_adr.
// Optional feature: define SIMON_ABORT_EN to add an 'abort' input that cancels
// an operation in progress without a done pulse.

module simon_round_core #(
    parameter int ROUNDS = 72,
    parameter int WORD   = 64
) (
    input  logic              clk,
    input  logic              res_n,      // active-high asynchronous reset
    input  logic              start,
    input  logic              ctrl,
    input  logic              key_ready,
`ifdef SIMON_ABORT_EN
    input  logic              abort,
`endif
    input  logic [2*WORD-1:0] in,
    input  logic [WORD-1:0]   key,
    output logic [6:0]        key_adr,
    output logic [2*WORD-1:0] out,
    output logic              busy,
    output logic              done
);

    localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);
    localparam logic [6:0] LAST_ADR = 7'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORD-1:0]     x_q, x_d;
    logic [WORD-1:0]     y_q, y_d;
    logic                mode_q, mode_d;     // 0 = encrypt, 1 = decrypt
    logic [6:0]          rnd_q, rnd_d;
    logic [6:0]          adr_q, adr_d;
    logic [2*WORD-1:0]   out_q, out_d;
    logic                done_q, done_d;

    // Simon round function: (ROL1 & ROL8) ^ ROL2.
    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int sh);
        return (v << sh) | (v >> (WORD - sh));
    endfunction

    function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // Next-state logic: FSM transitions plus one round of the datapath.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        rnd_d   = rnd_q;
        adr_d   = adr_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Start without a completed key schedule is dropped, not queued.
                if (start && key_ready) begin
                    x_d     = in[2*WORD-1:WORD];
                    y_d     = in[WORD-1:0];
                    mode_d  = ctrl;
                    adr_d   = ctrl ? LAST_ADR : 7'd0;
                    rnd_d   = 7'd0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // Bubble cycle: the key memory output settles for the first address.
                state_d = S_RUN;
            end

            S_RUN: begin
                if (mode_q) begin
                    x_d = y_q;
                    y_d = x_q ^ simon_f(y_q) ^ key;
                    // Decrypt walks keys downward and holds at address 0.
                    adr_d = (adr_q == 7'd0) ? 7'd0 : adr_q - 7'd1;
                end else begin
                    x_d = y_q ^ simon_f(x_q) ^ key;
                    y_d = x_q;
                    // Encrypt walks keys upward and holds at the last address.
                    adr_d = (adr_q == LAST_ADR) ? LAST_ADR : adr_q + 7'd1;
                end
                rnd_d = rnd_q + 7'd1;

                // Only the final round result ever reaches the output port.
                if (rnd_q == LAST_RND) begin
                    out_d   = {x_d, y_d};
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SIMON_ABORT_EN
        // Abort cancels LOAD/RUN only; in IDLE a simultaneous start wins.
        if (abort && (state_q == S_LOAD || state_q == S_RUN)) begin
            state_d = S_IDLE;
            out_d   = out_q;
            done_d  = 1'b0;
            adr_d   = 7'd0;
            rnd_d   = rnd_q;
        end
`endif
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            rnd_q   <= '0;
            adr_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values, avoiding ordering races.
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
            adr_q   <= adr_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign key_adr = adr_q;
    assign out     = out_q;
    assign done    = done_q;
    assign busy    = (state_q == S_LOAD) || (state_q == S_RUN);

endmodule

// File: tb/tb_simon_round_core.sv
// Directed self-checking bench for simon_round_core using the Simon 128/256
// reference vector. Define SIMON_ABORT_EN to also exercise the abort input.

module tb_simon_round_core;

    localparam logic [127:0] PT = 128'h74206e69206d6f6f_6d69732061207369;
    localparam logic [127:0] CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

    logic         clk = 1'b0;
    logic         res_n = 1'b1;
    logic         start = 1'b0;
    logic         ctrl = 1'b0;
    logic         key_ready = 1'b1;
    logic         abort = 1'b0;
    logic [127:0] in_blk = '0;
    logic [63:0]  key;
    logic [6:0]   key_adr;
    logic [127:0] out_blk;
    logic         busy;
    logic         done;

    logic [63:0]  kmem [72];

    int n_checks = 0;
    int n_fail   = 0;

    // Results gathered by run_block.
    int           r_lat;
    int           r_done_cnt;
    logic [127:0] r_out;
    logic         r_busy_load;
    logic         r_busy_done;
    logic [6:0]   r_adr_first;
    logic [6:0]   r_adr_max;
    logic [6:0]   r_adr_last;

    simon_round_core dut (
        .clk       (clk),
        .res_n     (res_n),
        .start     (start),
        .ctrl      (ctrl),
        .key_ready (key_ready),
`ifdef SIMON_ABORT_EN
        .abort     (abort),
`endif
        .in        (in_blk),
        .key       (key),
        .key_adr   (key_adr),
        .out       (out_blk),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Same-cycle key memory read.
    assign key = (key_adr < 7'd72) ? kmem[key_adr] : '0;

    function automatic logic [63:0] ror(input logic [63:0] v, input int sh);
        return (v >> sh) | (v << (64 - sh));
    endfunction

    // Simon 128/256 key expansion (m = 4, z4 sequence).
    task automatic expand_keys();
        logic [0:61] z4;
        logic [63:0] tmp;
        z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
        kmem[0] = 64'h0706050403020100;
        kmem[1] = 64'h0f0e0d0c0b0a0908;
        kmem[2] = 64'h1716151413121110;
        kmem[3] = 64'h1f1e1d1c1b1a1918;
        for (int i = 0; i < 68; i++) begin
            tmp = ror(kmem[i+3], 3) ^ kmem[i+1];
            tmp = tmp ^ ror(tmp, 1);
            kmem[i+4] = ~kmem[i] ^ tmp ^ {63'd0, z4[i % 62]} ^ 64'd3;
        end
    endtask

    // Drives one start and observes 150 cycles; c counts posedges since the start edge.
    task automatic run_block(input logic mode, input logic [127:0] blk, input logic poke);
        r_lat = -1;
        r_done_cnt = 0;
        r_out = '0;
        r_busy_load = 1'b0;
        r_busy_done = 1'b1;
        r_adr_first = '0;
        r_adr_max = '0;
        @(negedge clk);
        ctrl = mode;
        in_blk = blk;
        start = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ctrl = ~mode;
                in_blk = ~blk;
                r_busy_load = busy;
                r_adr_first = key_adr;
            end
            start = poke && (c == 20 || c == 74);
            if (key_adr > r_adr_max) r_adr_max = key_adr;
            if (done === 1'b1) begin
                r_done_cnt++;
                if (r_lat < 0) begin
                    r_lat = c;
                    r_out = out_blk;
                    r_busy_done = busy;
                end
            end
        end
        start = 1'b0;
        r_adr_last = key_adr;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (out_blk !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out_blk); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (key_adr !== 7'd0) begin n_fail++; $display("FAIL reset_key_adr: got %0d want 0", key_adr); end
        res_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt();
        run_block(1'b0, PT, 1'b0);
        n_checks++; if (r_out !== CT) begin n_fail++; $display("FAIL enc_out: got %h want %h", r_out, CT); end
        n_checks++; if (r_lat !== 74) begin n_fail++; $display("FAIL enc_latency: got %0d want 74", r_lat); end
        n_checks++; if (r_done_cnt !== 1) begin n_fail++; $display("FAIL enc_done_count: got %0d want 1", r_done_cnt); end
        n_checks++; if (r_busy_load !== 1'b1) begin n_fail++; $display("FAIL enc_busy_load: got %b want 1", r_busy_load); end
        n_checks++; if (r_busy_done !== 1'b0) begin n_fail++; $display("FAIL enc_busy_at_done: got %b want 0", r_busy_done); end
        n_checks++; if (r_adr_first !== 7'd0) begin n_fail++; $display("FAIL enc_adr_first: got %0d want 0", r_adr_first); end
        n_checks++; if (r_adr_max !== 7'd71) begin n_fail++; $display("FAIL enc_adr_max: got %0d want 71", r_adr_max); end
        n_checks++; if (r_adr_last !== 7'd71) begin n_fail++; $display("FAIL enc_adr_saturate: got %0d want 71", r_adr_last); end
        n_checks++; if (out_blk !== CT) begin n_fail++; $display("FAIL enc_out_held: got %h want %h", out_blk, CT); end
    endtask

    task automatic test_decrypt();
        run_block(1'b1, CT, 1'b0);
        n_checks++; if (r_out !== PT) begin n_fail++; $display("FAIL dec_out: got %h want %h", r_out, PT); end
        n_checks++; if (r_lat !== 74) begin n_fail++; $display("FAIL dec_latency: got %0d want 74", r_lat); end
        n_checks++; if (r_done_cnt !== 1) begin n_fail++; $display("FAIL dec_done_count: got %0d want 1", r_done_cnt); end
        n_checks++; if (r_adr_first !== 7'd71) begin n_fail++; $display("FAIL dec_adr_first: got %0d want 71", r_adr_first); end
        n_checks++; if (r_adr_max !== 7'd71) begin n_fail++; $display("FAIL dec_adr_underflow: max %0d want 71", r_adr_max); end
        n_checks++; if (r_adr_last !== 7'd0) begin n_fail++; $display("FAIL dec_adr_saturate: got %0d want 0", r_adr_last); end
    endtask

    task automatic test_gating();
        logic busy_seen;
        logic done_seen;
        busy_seen = 1'b0;
        done_seen = 1'b0;
        key_ready = 1'b0;
        @(negedge clk);
        ctrl = 1'b0;
        in_blk = PT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 90; c++) begin
            if (busy !== 1'b0) busy_seen = 1'b1;
            if (done !== 1'b0) done_seen = 1'b1;
            @(negedge clk);
        end
        key_ready = 1'b1;
        n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL gate_busy: got %b want 0", busy_seen); end
        n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL gate_done: got %b want 0", done_seen); end
        n_checks++; if (out_blk !== PT) begin n_fail++; $display("FAIL gate_out_held: got %h want %h", out_blk, PT); end
    endtask

    task automatic test_back_to_back();
        run_block(1'b0, PT, 1'b1);
        n_checks++; if (r_done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", r_done_cnt); end
        n_checks++; if (r_out !== CT) begin n_fail++; $display("FAIL b2b_out: got %h want %h", r_out, CT); end
        n_checks++; if (r_lat !== 74) begin n_fail++; $display("FAIL b2b_latency: got %0d want 74", r_lat); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        ctrl = 1'b1;
        in_blk = CT;
        start = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        res_n = 1'b1;
        #1;
        n_checks++; if (out_blk !== '0) begin n_fail++; $display("FAIL midrst_out: got %h want 0", out_blk); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
        n_checks++; if (key_adr !== 7'd0) begin n_fail++; $display("FAIL midrst_key_adr: got %0d want 0", key_adr); end
        @(negedge clk);
        res_n = 1'b0;
        run_block(1'b0, PT, 1'b0);
        n_checks++; if (r_out !== CT) begin n_fail++; $display("FAIL midrst_rerun_out: got %h want %h", r_out, CT); end
        n_checks++; if (r_done_cnt !== 1) begin n_fail++; $display("FAIL midrst_rerun_done: got %0d want 1", r_done_cnt); end
    endtask

`ifdef SIMON_ABORT_EN
    task automatic test_abort();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        ctrl = 1'b0;
        in_blk = PT;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (key_adr !== 7'd0) begin n_fail++; $display("FAIL abort_key_adr: got %0d want 0", key_adr); end
        n_checks++; if (out_blk !== CT) begin n_fail++; $display("FAIL abort_out_held: got %h want %h", out_blk, CT); end
        for (int c = 0; c < 90; c++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        // start and abort together in IDLE: start wins; abort held into LOAD cancels.
        ctrl = 1'b0;
        in_blk = PT;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_start_wins: got %b want 1", busy); end
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_in_load: got %b want 0", busy); end
        run_block(1'b1, CT, 1'b0);
        n_checks++; if (r_out !== PT) begin n_fail++; $display("FAIL abort_rerun_out: got %h want %h", r_out, PT); end
    endtask
`endif

    initial begin
        expand_keys();
        test_reset();
        test_encrypt();
        test_decrypt();
        test_gating();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SIMON_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
